cdb_arbiter: RTL and testbench

- Round-robin arbiter sharing the single common data bus (CDB) writeback port between NB_FU functional units in the execute stage.
- Sits between the FU outputs and the register-file write / issue-queue wakeup logic.
- Registers one granted result per cycle with valid/ready handshakes on both sides, and a flush input.

---
 rtl/cdb_arbiter.sv | 102 ++++++++++
 tb/tb_cdb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared common-data-bus writeback port.
// Optional macro CDB_ARB_STATS_EN adds per-FU grant counters and a stall counter.
module cdb_arbiter #(
  parameter int NB_FU = 4,
  parameter int XLEN  = 64,
  parameter int ID_W  = 4,
  parameter int PRD_W = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush_i,
  input  logic [NB_FU-1:0]       fu_valid_i,
  output logic [NB_FU-1:0]       fu_ready_o,
  input  logic [NB_FU*ID_W-1:0]  fu_id_i,
  input  logic [NB_FU*PRD_W-1:0] fu_prd_i,
  input  logic [NB_FU*XLEN-1:0]  fu_data_i,
  output logic                   cdb_valid_o,
  output logic [ID_W-1:0]        cdb_id_o,
  output logic [PRD_W-1:0]       cdb_prd_o,
  output logic [XLEN-1:0]        cdb_data_o,
`ifdef CDB_ARB_STATS_EN
  output logic [NB_FU*32-1:0]    grant_cnt_o,
  output logic [31:0]            stall_cnt_o,
`endif
  input  logic                   cdb_ready_i
);

  localparam int RR_W = (NB_FU > 1) ? $clog2(NB_FU) : 1;

  logic [RR_W-1:0]  rr_q;
  logic [RR_W-1:0]  rr_next;
  logic             slot_free;
  logic [NB_FU-1:0] grant;
  logic             grant_any;
  logic [RR_W-1:0]  grant_idx;
  int               idx;

  assign slot_free = !cdb_valid_o || cdb_ready_i;

  // First valid FU at or after rr_q, wrapping modulo NB_FU (not a power of 2 in general).
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (slot_free && !flush_i && rstn) begin
      for (int i = 0; i < NB_FU; i++) begin
        idx = (int'(rr_q) + i) % NB_FU;
        if (!grant_any && fu_valid_i[idx]) begin
          grant_any  = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = RR_W'(idx);
        end
      end
    end
  end

  assign rr_next    = (grant_idx == RR_W'(NB_FU - 1)) ? '0 : grant_idx + 1'b1;
  assign fu_ready_o = grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cdb_valid_o <= 1'b0;
      cdb_id_o    <= '0;
      cdb_prd_o   <= '0;
      cdb_data_o  <= '0;
      rr_q        <= '0;
    end else if (grant_any) begin
      cdb_valid_o <= 1'b1;
      cdb_id_o    <= fu_id_i[grant_idx*ID_W +: ID_W];
      cdb_prd_o   <= fu_prd_i[grant_idx*PRD_W +: PRD_W];
      cdb_data_o  <= fu_data_i[grant_idx*XLEN +: XLEN];
      rr_q        <= rr_next;
    end else if (flush_i || cdb_ready_i) begin
      cdb_valid_o <= 1'b0;
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NB_FU];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NB_FU; k++) grant_cnt_q[k] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NB_FU; k++) begin
        if (fu_valid_i[k] && grant[k]) grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
      end
      if (cdb_valid_o && !cdb_ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < NB_FU; k++) grant_cnt_o[k*32 +: 32] = grant_cnt_q[k];
  end
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table, hand sequences and a randomized run
// against a queue-based model of the round-robin rules.
module tb_cdb_arbiter;
  localparam int NB    = 4;
  localparam int XLEN  = 64;
  localparam int ID_W  = 4;
  localparam int PRD_W = 6;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                flush = 1'b0;
  logic [NB-1:0]       fu_valid = '0;
  logic [NB-1:0]       fu_ready;
  logic [NB*ID_W-1:0]  fu_id = '0;
  logic [NB*PRD_W-1:0] fu_prd = '0;
  logic [NB*XLEN-1:0]  fu_data = '0;
  logic                cdb_valid;
  logic [ID_W-1:0]     cdb_id;
  logic [PRD_W-1:0]    cdb_prd;
  logic [XLEN-1:0]     cdb_data;
  logic                cdb_ready = 1'b1;
`ifdef CDB_ARB_STATS_EN
  logic [NB*32-1:0]    grant_cnt;
  logic [31:0]         stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NB_FU(NB), .XLEN(XLEN), .ID_W(ID_W), .PRD_W(PRD_W)) dut (
    .clk(clk), .rstn(rstn), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(fu_ready),
    .fu_id_i(fu_id), .fu_prd_i(fu_prd), .fu_data_i(fu_data),
    .cdb_valid_o(cdb_valid), .cdb_id_o(cdb_id), .cdb_prd_o(cdb_prd),
    .cdb_data_o(cdb_data),
`ifdef CDB_ARB_STATS_EN
    .grant_cnt_o(grant_cnt), .stall_cnt_o(stall_cnt),
`endif
    .cdb_ready_i(cdb_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rstn;
    logic       flush;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_rdy;
    logic       exp_v;
    logic       chk_id;
    logic [3:0] exp_id;
  } vec_t;

  vec_t tbl[22];

  // Random-phase model state
  logic            m_valid;
  logic [ID_W-1:0] m_id;
  logic [PRD_W-1:0] m_prd;
  logic [XLEN-1:0] m_data;
  int              m_rr;

  function automatic int model_grant(input logic [NB-1:0] v, input int rr);
    int order[$];
    for (int i = 0; i < NB; i++) order.push_back((rr + i) % NB);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  initial begin
    logic [3:0] exp_rdy_r;
    logic [3:0] granted;
    int g;

    // Table fill: FU k carries id k, prd 16+k, data 'hA000+k.
    tbl[0]  = '{1'b0,1'b0,4'b1111,1'b1, 4'b0000,1'b0,1'b1,4'd0};
    tbl[1]  = '{1'b0,1'b0,4'b1111,1'b1, 4'b0000,1'b0,1'b1,4'd0};
    tbl[2]  = '{1'b0,1'b0,4'b1111,1'b1, 4'b0000,1'b0,1'b1,4'd0};
    tbl[3]  = '{1'b1,1'b0,4'b1111,1'b1, 4'b0001,1'b0,1'b0,4'd0};
    tbl[4]  = '{1'b1,1'b0,4'b1111,1'b1, 4'b0010,1'b1,1'b1,4'd0};
    tbl[5]  = '{1'b1,1'b0,4'b1111,1'b1, 4'b0100,1'b1,1'b1,4'd1};
    tbl[6]  = '{1'b1,1'b0,4'b1111,1'b1, 4'b1000,1'b1,1'b1,4'd2};
    tbl[7]  = '{1'b1,1'b0,4'b1111,1'b1, 4'b0001,1'b1,1'b1,4'd3};
    tbl[8]  = '{1'b1,1'b0,4'b0010,1'b1, 4'b0010,1'b1,1'b1,4'd0};
    tbl[9]  = '{1'b1,1'b0,4'b0011,1'b1, 4'b0001,1'b1,1'b1,4'd1};
    tbl[10] = '{1'b1,1'b0,4'b0011,1'b1, 4'b0010,1'b1,1'b1,4'd0};
    tbl[11] = '{1'b1,1'b0,4'b0000,1'b1, 4'b0000,1'b1,1'b1,4'd1};
    tbl[12] = '{1'b1,1'b0,4'b0000,1'b1, 4'b0000,1'b0,1'b0,4'd0};
    tbl[13] = '{1'b1,1'b0,4'b0100,1'b1, 4'b0100,1'b0,1'b0,4'd0};
    tbl[14] = '{1'b1,1'b1,4'b0100,1'b1, 4'b0000,1'b1,1'b1,4'd2};
    tbl[15] = '{1'b1,1'b0,4'b0100,1'b1, 4'b0100,1'b0,1'b0,4'd0};
    tbl[16] = '{1'b1,1'b0,4'b0001,1'b0, 4'b0000,1'b1,1'b1,4'd2};
    tbl[17] = '{1'b1,1'b0,4'b0001,1'b0, 4'b0000,1'b1,1'b1,4'd2};
    tbl[18] = '{1'b1,1'b0,4'b0001,1'b0, 4'b0000,1'b1,1'b1,4'd2};
    tbl[19] = '{1'b1,1'b0,4'b0001,1'b0, 4'b0000,1'b1,1'b1,4'd2};
    tbl[20] = '{1'b1,1'b0,4'b0001,1'b1, 4'b0001,1'b1,1'b1,4'd2};
    tbl[21] = '{1'b1,1'b0,4'b0000,1'b1, 4'b0000,1'b1,1'b1,4'd0};

    for (int k = 0; k < NB; k++) begin
      fu_id[k*ID_W +: ID_W]     = ID_W'(k);
      fu_prd[k*PRD_W +: PRD_W]  = PRD_W'(16 + k);
      fu_data[k*XLEN +: XLEN]   = 64'hA000 + 64'(k);
    end

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      rstn = tbl[i].rstn; flush = tbl[i].flush;
      fu_valid = tbl[i].valid; cdb_ready = tbl[i].ready;
      #4;
      chk($sformatf("tbl%0d_ready", i), 64'(fu_ready), 64'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_valid", i), 64'(cdb_valid), 64'(tbl[i].exp_v));
      if (tbl[i].chk_id) chk($sformatf("tbl%0d_id", i), 64'(cdb_id), 64'(tbl[i].exp_id));
      @(posedge clk); #1;
    end

    // Backpressure on an FU2 result with a recognisable payload.
    fu_prd[2*PRD_W +: PRD_W] = 6'd17;
    fu_data[2*XLEN +: XLEN]  = 64'hDEAD_BEEF;
    fu_valid = 4'b0100; cdb_ready = 1'b1; flush = 1'b0;
    #4 chk("bp_grant_fu2", 64'(fu_ready), 64'h4);
    @(posedge clk); #1;
    fu_valid = 4'b0001; cdb_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk("bp_valid", 64'(cdb_valid), 64'h1);
      chk("bp_prd", 64'(cdb_prd), 64'd17);
      chk("bp_data", cdb_data, 64'hDEAD_BEEF);
      chk("bp_no_grant", 64'(fu_ready), 64'h0);
      @(posedge clk); #1;
    end
    cdb_ready = 1'b1;
    #4 chk("bp_release_grant", 64'(fu_ready), 64'h1);
    @(posedge clk); #1;
    chk("bp_release_id", 64'(cdb_id), 64'd0);
    fu_valid = '0;

    // Asynchronous reset with a result on the bus.
    fu_valid = 4'b0010;
    @(posedge clk); #1;
    fu_valid = '0;
    chk("mrst_pre_valid", 64'(cdb_valid), 64'h1);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_valid", 64'(cdb_valid), 64'h0);
    chk("mrst_data", cdb_data, 64'h0);
    fu_valid = 4'b1111;
    #1 chk("mrst_ready", 64'(fu_ready), 64'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #4 chk("mrst_first_grant", 64'(fu_ready), 64'h1);
    @(posedge clk); #1;

`ifdef CDB_ARB_STATS_EN
    rstn = 1'b0; fu_valid = '0; cdb_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    chk("stat_rst_grant1", 64'(grant_cnt[32 +: 32]), 64'd0);
    rstn = 1'b1; fu_valid = 4'b0010;
    repeat (10) @(posedge clk);
    #1 fu_valid = '0; cdb_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stat_grant1", 64'(grant_cnt[32 +: 32]), 64'd10);
    chk("stat_grant0", 64'(grant_cnt[0 +: 32]), 64'd0);
    chk("stat_stall", 64'(stall_cnt), 64'd3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("stat_flush_keep", 64'(grant_cnt[32 +: 32]), 64'd10);
    rstn = 1'b0; #1;
    chk("stat_rst_grant", 64'(grant_cnt[32 +: 32]), 64'd0);
    chk("stat_rst_stall", 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    cdb_ready = 1'b1;
`endif

    // Randomized run against the model, starting from reset.
    rstn = 1'b0; fu_valid = '0; flush = 1'b0; cdb_ready = 1'b1;
    m_valid = 1'b0; m_id = '0; m_prd = '0; m_data = '0; m_rr = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rstn      = ($urandom_range(0, 99) >= 2);
      flush     = ($urandom_range(0, 99) < 10);
      cdb_ready = ($urandom_range(0, 99) < 70);
      if (!rstn) begin
        m_valid = 1'b0; m_id = '0; m_prd = '0; m_data = '0; m_rr = 0;
      end
      g = -1;
      if (rstn && !flush && (!m_valid || cdb_ready)) g = model_grant(fu_valid, m_rr);
      exp_rdy_r = '0;
      if (g >= 0) exp_rdy_r[g] = 1'b1;
      #4;
      chk("rnd_ready", 64'(fu_ready), 64'(exp_rdy_r));
      chk("rnd_valid", 64'(cdb_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd_id", 64'(cdb_id), 64'(m_id));
        chk("rnd_prd", 64'(cdb_prd), 64'(m_prd));
        chk("rnd_data", cdb_data, m_data);
      end
      granted = fu_valid & fu_ready;
      @(posedge clk); #1;
      if (rstn) begin
        if (g >= 0) begin
          m_valid = 1'b1;
          m_id    = fu_id[g*ID_W +: ID_W];
          m_prd   = fu_prd[g*PRD_W +: PRD_W];
          m_data  = fu_data[g*XLEN +: XLEN];
          m_rr    = (g + 1) % NB;
        end else if (flush || cdb_ready) begin
          m_valid = 1'b0;
        end
      end
      // An FU keeps valid and payload until granted; only then may it change.
      for (int k = 0; k < NB; k++) begin
        if (granted[k] || !fu_valid[k]) begin
          fu_valid[k] = ($urandom_range(0, 99) < 60);
          fu_id[k*ID_W +: ID_W]    = ID_W'($urandom);
          fu_prd[k*PRD_W +: PRD_W] = PRD_W'($urandom);
          fu_data[k*XLEN +: XLEN]  = {$urandom, $urandom};
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
